// File: rtl/hnm_row_decoder_pkg.sv
// hnm_row_decoder_pkg: shared HNM geometry and decoder FSM encoding
package hnm_row_decoder_pkg;
  localparam int NCOLS_HNM = 16;
  localparam int ROWINDEXBITS_HNM = 4;
  localparam int COLINDEXBITS_HNM = $clog2(NCOLS_HNM);
  localparam int SSIDBITS = ROWINDEXBITS_HNM + COLINDEXBITS_HNM;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SCAN = 2'd2} state_t;
endpackage

// File: rtl/hnm_row_fifo.sv
// hnm_row_fifo: power-of-two row buffer with wrap-bit pointers and combinational read
module hnm_row_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic wr, rd;
  assign empty = wptr_q == rptr_q;
  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  assign rd_data = mem_q[rptr_q[AW-1:0]];
  // advance pointers and store the incoming row; write and pop may coincide
  always_comb begin
    mem_d = mem_q;
    wptr_d = wptr_q + {{AW{1'b0}}, wr};
    rptr_d = rptr_q + {{AW{1'b0}}, rd};
    if (wr) mem_d[wptr_q[AW-1:0]] = wr_data;
  end
  // pointer and storage registers, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/hnm_row_decoder.sv
// hnm_row_decoder: buffers HNM row bitmaps and streams one SSID per set bit, lowest column first
module hnm_row_decoder
  import hnm_row_decoder_pkg::*;
#(
  parameter int NCOLS_HNM = hnm_row_decoder_pkg::NCOLS_HNM,
  parameter int ROWINDEXBITS_HNM = hnm_row_decoder_pkg::ROWINDEXBITS_HNM,
  parameter int COLINDEXBITS_HNM = $clog2(NCOLS_HNM),
  parameter int FIFODEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     rowValid,
  input  logic [ROWINDEXBITS_HNM-1:0]              rowPassed,
  input  logic [NCOLS_HNM-1:0]                     rowReadOutput,
  output logic                                     rowReady,
  output logic [ROWINDEXBITS_HNM+COLINDEXBITS_HNM-1:0] SSID_out,
  output logic                                     SSID_valid,
  input  logic                                     SSID_ready,
  output logic                                     rowDone,
  output logic                                     overflow,
  output logic                                     busy
);
  localparam int FW = ROWINDEXBITS_HNM + NCOLS_HNM;
  state_t state_q, state_d;
  logic [ROWINDEXBITS_HNM-1:0] row_q, row_d;
  logic [NCOLS_HNM-1:0] mask_q, mask_d, col_bit;
  logic overflow_q, overflow_d;
  logic fifo_full, fifo_empty, push, pop, hs, last;
  logic [FW-1:0] fifo_rd;
  logic [COLINDEXBITS_HNM-1:0] col;
  assign rowReady = !fifo_full;
  assign push = rowValid && !fifo_full;
  assign pop = state_q == LOAD;
  hnm_row_fifo #(.WIDTH(FW), .DEPTH(FIFODEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(push),
    .wr_data({rowPassed, rowReadOutput}),
    .rd_en(pop),
    .rd_data(fifo_rd),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  // priority encoder: index of the lowest set bit of the working mask
  always_comb begin
    col = '0;
    for (int i = NCOLS_HNM - 1; i >= 0; i--) if (mask_q[i]) col = COLINDEXBITS_HNM'(i);
  end
  assign col_bit = mask_q & (~mask_q + NCOLS_HNM'(1));
  assign last = (mask_q & ~col_bit) == '0;
  assign SSID_valid = (state_q == SCAN) && |mask_q;
  assign SSID_out = SSID_valid ? {row_q, col} : '0;
  assign hs = SSID_valid && SSID_ready;
  assign rowDone = (state_q == SCAN) && (!(|mask_q) || (hs && last));
  assign busy = !fifo_empty || state_q != IDLE;
  assign overflow = overflow_q;
  // next state: fetch a row, retire its bits one per handshake, chain straight into the next row
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    mask_d = mask_q;
    overflow_d = overflow_q | (rowValid & fifo_full);
    case (state_q)
      IDLE: state_d = fifo_empty ? IDLE : LOAD;
      LOAD: begin
        row_d = fifo_rd[FW-1 -: ROWINDEXBITS_HNM];
        mask_d = fifo_rd[NCOLS_HNM-1:0];
        state_d = SCAN;
      end
      SCAN: begin
        if (hs) mask_d = mask_q & ~col_bit;
        if (rowDone) state_d = (!fifo_empty || push) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset discards the current row and forgets any overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q <= '0;
      mask_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      mask_q <= mask_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_hnm_row_decoder.sv
// tb_hnm_row_decoder: directed and randomized checks of the row-to-SSID decoder
module tb_hnm_row_decoder;
  logic clk = 1'b0;
  logic reset, rowValid, SSID_ready, rowReady, SSID_valid, rowDone, overflow, busy;
  logic [3:0] rowPassed;
  logic [15:0] rowReadOutput;
  logic [7:0] SSID_out;
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  hnm_row_decoder #(.NCOLS_HNM(16), .ROWINDEXBITS_HNM(4), .COLINDEXBITS_HNM(4), .FIFODEPTH(4)) dut (
    .clk(clk), .reset(reset), .rowValid(rowValid), .rowPassed(rowPassed),
    .rowReadOutput(rowReadOutput), .rowReady(rowReady), .SSID_out(SSID_out),
    .SSID_valid(SSID_valid), .SSID_ready(SSID_ready), .rowDone(rowDone),
    .overflow(overflow), .busy(busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // every set bit of a row becomes one SSID, column 0 first
  function automatic void model_row(logic [3:0] r, logic [15:0] bm);
    for (int c = 0; c < 16; c++) if (bm[c]) exp_q.push_back({r, 4'(c)});
  endfunction

  task automatic offer(logic [3:0] r, logic [15:0] bm);
    rowValid = 1'b1;
    rowPassed = r;
    rowReadOutput = bm;
  endtask

  task automatic step(string tag, logic v, logic [7:0] s, logic d, logic b);
    @(negedge clk);
    chk({tag, "_valid"}, SSID_valid, v);
    if (v) chk({tag, "_ssid"}, SSID_out, s);
    chk({tag, "_done"}, rowDone, d);
    chk({tag, "_busy"}, busy, b);
    @(posedge clk); #1;
  endtask

  task automatic run_rows(string tag, int rows, int budget);
    int d = 0;
    int cyc = 0;
    while (d < rows && cyc < budget) begin
      @(negedge clk);
      if (SSID_valid && SSID_ready) got_q.push_back(SSID_out);
      if (rowDone) d++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_rows"}, d, rows);
  endtask

  task automatic cmp_q(string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int offered, done_n, hold, nv;
    logic [7:0] prev;
    logic [15:0] bm;
    reset = 1'b0; rowValid = 1'b0; rowPassed = '0; rowReadOutput = '0; SSID_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("rst_valid", SSID_valid, 0); chk("rst_ssid", SSID_out, 0); chk("rst_done", rowDone, 0);
    chk("rst_ovf", overflow, 0); chk("rst_busy", busy, 0); chk("rst_ready", rowReady, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // row 8, free-running downstream: first SSID two edges after accept
    offer(4'd8, 16'h0189);
    step("r8_pre", 0, 0, 0, 0); rowValid = 1'b0;
    step("r8_acc", 0, 0, 0, 1); step("r8_load", 0, 0, 0, 1);
    step("r8_s0", 1, 8'h80, 0, 1); step("r8_s1", 1, 8'h83, 0, 1);
    step("r8_s2", 1, 8'h87, 0, 1); step("r8_s3", 1, 8'h88, 1, 1);
    step("r8_end", 0, 0, 0, 0);

    // same row with a five-cycle downstream stall on the second SSID
    offer(4'd8, 16'h0189);
    step("st_pre", 0, 0, 0, 0); rowValid = 1'b0;
    step("st_acc", 0, 0, 0, 1); step("st_load", 0, 0, 0, 1);
    step("st_s0", 1, 8'h80, 0, 1);
    SSID_ready = 1'b0;
    repeat (5) step("st_hold", 1, 8'h83, 0, 1);
    SSID_ready = 1'b1;
    step("st_s1", 1, 8'h83, 0, 1); step("st_s2", 1, 8'h87, 0, 1); step("st_s3", 1, 8'h88, 1, 1);
    step("st_end", 0, 0, 0, 0);

    // back-to-back rows 3 and 4: one LOAD bubble between them
    offer(4'd3, 16'h0060);
    step("bb_pre", 0, 0, 0, 0);
    offer(4'd4, 16'h10D6);
    step("bb_acc3", 0, 0, 0, 1); rowValid = 1'b0;
    step("bb_load3", 0, 0, 0, 1);
    step("bb_35", 1, 8'h35, 0, 1); step("bb_36", 1, 8'h36, 1, 1);
    step("bb_load4", 0, 0, 0, 1);
    step("bb_41", 1, 8'h41, 0, 1); step("bb_42", 1, 8'h42, 0, 1); step("bb_44", 1, 8'h44, 0, 1);
    step("bb_46", 1, 8'h46, 0, 1); step("bb_47", 1, 8'h47, 0, 1); step("bb_4c", 1, 8'h4C, 1, 1);
    step("bb_end", 0, 0, 0, 0);

    // empty row: no SSID, one rowDone, back to idle
    offer(4'd2, 16'h0000);
    step("e_pre", 0, 0, 0, 0); rowValid = 1'b0;
    step("e_acc", 0, 0, 0, 1); step("e_load", 0, 0, 0, 1);
    step("e_done", 0, 0, 1, 1); step("e_idle", 0, 0, 0, 0);

    // random rows and random backpressure, never offered into a possibly full buffer
    offered = 0; done_n = 0; hold = 0; prev = '0;
    for (int cyc = 0; cyc < 4000 && !(offered == 40 && done_n == 40); cyc++) begin
      SSID_ready = $urandom_range(0, 3) != 0;
      rowValid = offered < 40 && offered - done_n < 4 && $urandom_range(0, 2) == 0;
      if (rowValid) begin
        rowPassed = 4'($urandom);
        bm = $urandom_range(0, 4) == 0 ? 16'h0000 : 16'($urandom);
        rowReadOutput = bm;
        model_row(rowPassed, bm);
        offered++;
      end
      @(negedge clk);
      if (rowValid) chk("rnd_ready", rowReady, 1);
      if (hold != 0) begin
        chk("rnd_hold_valid", SSID_valid, 1);
        chk("rnd_hold_ssid", SSID_out, prev);
      end
      if (SSID_valid && SSID_ready) got_q.push_back(SSID_out);
      if (rowDone) done_n++;
      hold = int'(SSID_valid && !SSID_ready);
      prev = SSID_out;
      @(posedge clk); #1;
    end
    rowValid = 1'b0;
    chk("rnd_rows", done_n, 40);
    chk("rnd_ovf", overflow, 0);
    cmp_q("rnd_ssid");

    // downstream stalled on row 1: four rows fill the buffer, the next two are dropped
    SSID_ready = 1'b0;
    offer(4'd1, 16'h0003); model_row(4'd1, 16'h0003);
    @(posedge clk); #1; rowValid = 1'b0;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      offer(4'(10 + i), 16'h0001 << i);
      @(negedge clk);
      chk("ovf_ready", rowReady, i < 4);
      chk("ovf_sticky", overflow, i > 4);
      if (i < 4) model_row(4'(10 + i), 16'h0001 << i);
      @(posedge clk); #1;
    end
    rowValid = 1'b0;
    @(negedge clk);
    chk("ovf_flag", overflow, 1); chk("ovf_full", rowReady, 0);
    chk("ovf_stall_v", SSID_valid, 1); chk("ovf_stall_s", SSID_out, 8'h10);
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    SSID_ready = 1'b1;
    run_rows("ovf_drain", 5, 200);
    cmp_q("ovf_ssid");
    @(negedge clk); chk("ovf_kept", overflow, 1);
    @(posedge clk); #1;

    // reset in the middle of row 4 with another row buffered behind it
    offer(4'd4, 16'h10D6); @(posedge clk); #1;
    offer(4'd7, 16'hFFFF); @(posedge clk); #1; rowValid = 1'b0;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("mr_pre_v", SSID_valid, 1); chk("mr_pre_s", SSID_out, 8'h42);
    #1 reset = 1'b0;
    #1;
    chk("mr_valid", SSID_valid, 0); chk("mr_ssid", SSID_out, 0); chk("mr_done", rowDone, 0);
    chk("mr_ovf", overflow, 0); chk("mr_busy", busy, 0); chk("mr_ready", rowReady, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (SSID_valid || rowDone) nv++;
      @(posedge clk); #1;
    end
    chk("mr_silent", nv, 0);
    chk("mr_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
